// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: sequences the expansion engine, captures its
// eleven round keys into a local bank and serves them through a req/ack read port.
module aes_key_sched_ctrl #(
    parameter int NR      = 10,
    parameter int TIMEOUT = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         key_load_in,
    input  logic [127:0] key_in,
    output logic         key_busy_out,
    output logic         key_ready_out,
    output logic         fault_out,
    output logic         ke_start_out,
    output logic [127:0] ke_key_out,
    input  logic [1:0]   ke_state_in,
    input  logic [127:0] ke_rkey_in,
    input  logic         rk_req_in,
    input  logic [3:0]   rk_idx_in,
    output logic         rk_ack_out,
    output logic [127:0] rk_key_out,
    output logic         rk_err_out
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [3:0]      LAST_IDX = 4'(NR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, CAPT, READY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         idx_q, idx_d;
    logic               fault_q, fault_d;
    logic [127:0]       ke_key_q, ke_key_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [127:0]       rd_q;
    logic [127:0]       bank_q [0:NR];

    logic               bank_we;
    logic [3:0]         bank_waddr;
    logic               rd_en;
    logic [3:0]         rd_addr;
    logic               eng_active;

    assign eng_active = (ke_state_in != 2'd0);
    // Out-of-range indices still read a legal entry; the output is forced to 0 anyway.
    assign rd_addr    = (rk_idx_in > LAST_IDX) ? 4'd0 : rk_idx_in;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        fault_d    = fault_q;
        ke_key_d   = ke_key_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        bank_we    = 1'b0;
        bank_waddr = idx_q;
        rd_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_load_in) begin
                    ke_key_d = key_in;
                    fault_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (eng_active) begin
                    bank_we    = 1'b1;
                    bank_waddr = 4'd0;
                    idx_d      = 4'd1;
                    state_d    = CAPT;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPT: begin
                if (eng_active) begin
                    bank_we = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = READY;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end
            end
            READY: begin
                // A new load always beats a read in the same cycle; the read stays pending.
                if (key_load_in) begin
                    ke_key_d = key_in;
                    fault_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = START;
                end else if (rk_req_in && !ack_q) begin
                    ack_d = 1'b1;
                    err_d = (rk_idx_in > LAST_IDX);
                    rd_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            fault_q  <= 1'b0;
            ke_key_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            fault_q  <= fault_d;
            ke_key_q <= ke_key_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    // Round-key bank with registered read; no reset so it maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (bank_we) begin
            bank_q[bank_waddr] <= ke_rkey_in;
        end
        if (rd_en) begin
            rd_q <= bank_q[rd_addr];
        end
    end

    assign key_busy_out  = (state_q == START) || (state_q == CAPT);
    assign key_ready_out = (state_q == READY);
    assign ke_start_out  = (state_q == START);
    assign fault_out     = fault_q;
    assign ke_key_out    = ke_key_q;
    assign rk_ack_out    = ack_q;
    assign rk_err_out    = err_q;
    assign rk_key_out    = (ack_q && !err_q) ? rd_q : '0;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: behavioural AES-128 expansion engine plus a
// scoreboard of expected round-key reads.
module tb_aes_key_sched_ctrl;

    localparam int NR      = 10;
    localparam int TIMEOUT = 32;

    typedef logic [0:10][127:0] sched_t;
    typedef struct {
        logic [127:0] key;
        logic         err;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         key_load_in = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_busy_out, key_ready_out, fault_out, ke_start_out;
    logic [127:0] ke_key_out;
    logic [1:0]   ke_state_in;
    logic [127:0] ke_rkey_in;
    logic         rk_req_in = 1'b0;
    logic [3:0]   rk_idx_in = '0;
    logic         rk_ack_out, rk_err_out;
    logic [127:0] rk_key_out;

    int tests = 0;
    int fails = 0;

    logic [7:0] sbox_t [0:255];
    sched_t     cur_s;
    exp_t       sb_q [$];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    aes_key_sched_ctrl #(.NR(NR), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .key_load_in(key_load_in), .key_in(key_in),
        .key_busy_out(key_busy_out), .key_ready_out(key_ready_out), .fault_out(fault_out),
        .ke_start_out(ke_start_out), .ke_key_out(ke_key_out),
        .ke_state_in(ke_state_in), .ke_rkey_in(ke_rkey_in),
        .rk_req_in(rk_req_in), .rk_idx_in(rk_idx_in),
        .rk_ack_out(rk_ack_out), .rk_key_out(rk_key_out), .rk_err_out(rk_err_out)
    );

    always #5 CLK = ~CLK;

    // ---------------- AES-128 reference key expansion ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic sched_t expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        sched_t      s;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return s;
    endfunction

    // ---------------- engine model ----------------
    // eng_mode: 0 = normal, 1 = never leaves idle, 2 = drops active after 5 cycles
    int     eng_mode = 0;
    logic   eng_act;
    int     eng_rnd;
    sched_t eng_s;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            eng_act <= 1'b0;
            eng_rnd <= 0;
        end else if (!eng_act) begin
            if (ke_start_out && eng_mode != 1) begin
                eng_s   <= expand(ke_key_out);
                eng_act <= 1'b1;
                eng_rnd <= 0;
            end
        end else begin
            if (eng_rnd == NR || (eng_mode == 2 && eng_rnd == 4)) eng_act <= 1'b0;
            else eng_rnd <= eng_rnd + 1;
        end
    end

    assign ke_state_in = eng_act ? ((eng_rnd % 2 == 1) ? 2'd3 : 2'd1) : 2'd0;
    assign ke_rkey_in  = eng_act ? eng_s[eng_rnd] : 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- helpers that also check ----------------
    // Starts at a negedge with the DUT in IDLE or READY; returns at the negedge where READY appears.
    task automatic expand_and_check(input logic [127:0] k, input int intrude_at, input string tag);
        int first_ready;
        first_ready = 0;
        key_load_in = 1'b1;
        key_in      = k;
        cur_s       = expand(k);
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            if (n == 1) begin
                key_load_in = 1'b0;
                key_in      = rand128();
                tests++;
                if (ke_start_out !== 1'b1 || ke_key_out !== k || fault_out !== 1'b0) begin
                    fails++;
                    $display("FAIL %s_start: start=%b fault=%b ke_key=%h, want start=1 fault=0 ke_key=%h",
                             tag, ke_start_out, fault_out, ke_key_out, k);
                end
            end
            if (intrude_at != 0 && n == intrude_at) begin
                key_load_in = 1'b1;
                key_in      = ~k;
            end
            if (intrude_at != 0 && n == intrude_at + 1) key_load_in = 1'b0;
            if (n == 12) begin
                tests++;
                if (key_busy_out !== 1'b1 || key_ready_out !== 1'b0) begin
                    fails++;
                    $display("FAIL %s_busy12: busy=%b ready=%b, want busy=1 ready=0", tag, key_busy_out, key_ready_out);
                end
            end
            if (key_ready_out && first_ready == 0) first_ready = n;
            if (first_ready != 0) break;
        end
        tests++;
        if (first_ready != 13 || key_busy_out !== 1'b0) begin
            fails++;
            $display("FAIL %s_ready_cycle: ready at T+%0d busy=%b, want T+13 busy=0", tag, first_ready, key_busy_out);
        end
        if (intrude_at != 0) begin
            tests++;
            if (ke_key_out !== k) begin
                fails++;
                $display("FAIL %s_intrude_key: ke_key=%h, want %h", tag, ke_key_out, k);
            end
        end
    endtask

    // Drives a request at the current negedge, pushes the expectation, and returns at the ack negedge.
    task automatic rd(input logic [3:0] idx, input int exp_wait, input bit hold);
        exp_t e;
        int   w;
        rk_req_in = 1'b1;
        rk_idx_in = idx;
        e.err = (idx > 4'(NR));
        e.key = e.err ? 128'h0 : cur_s[idx];
        sb_q.push_back(e);
        w = 0;
        do begin
            @(negedge CLK);
            w++;
        end while (!rk_ack_out && w < 20);
        e = sb_q.pop_front();
        tests++;
        if (rk_ack_out !== 1'b1 || w != exp_wait) begin
            fails++;
            $display("FAIL rd_latency idx=%0d: ack=%b after %0d cycles, want ack after %0d", idx, rk_ack_out, w, exp_wait);
        end
        tests++;
        if (rk_key_out !== e.key || rk_err_out !== e.err) begin
            fails++;
            $display("FAIL rd_data idx=%0d: key=%h err=%b, want key=%h err=%b", idx, rk_key_out, rk_err_out, e.key, e.err);
        end
        $display("[TB] read idx=%0d key=%h err=%b wait=%0d", idx, rk_key_out, rk_err_out, w);
        if (!hold) rk_req_in = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        tests++;
        if ({key_busy_out, key_ready_out, fault_out, ke_start_out, rk_ack_out, rk_err_out} !== 6'b0 ||
            ke_key_out !== 128'h0 || rk_key_out !== 128'h0) begin
            fails++;
            $display("FAIL %s: busy=%b ready=%b fault=%b start=%b ack=%b err=%b ke_key=%h rk_key=%h, want all 0",
                     tag, key_busy_out, key_ready_out, fault_out, ke_start_out, rk_ack_out, rk_err_out,
                     ke_key_out, rk_key_out);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check_all_zero("reset_values");
        RST = 1'b0;
        @(negedge CLK);
        check_all_zero("reset_idle");
    endtask

    task automatic test_fips();
        expand_and_check(FIPS_KEY, 0, "fips");
        @(negedge CLK);
        rd(4'd1, 1, 1'b0);
        tests++;
        if (rk_key_out !== FIPS_R1) begin
            fails++;
            $display("FAIL fips_r1: key=%h, want %h", rk_key_out, FIPS_R1);
        end
        @(negedge CLK);
        rd(4'd10, 1, 1'b0);
        tests++;
        if (rk_key_out !== FIPS_R10) begin
            fails++;
            $display("FAIL fips_r10: key=%h, want %h", rk_key_out, FIPS_R10);
        end
        @(negedge CLK);
        rd(4'd0, 1, 1'b0);
        tests++;
        if (rk_key_out !== FIPS_KEY) begin
            fails++;
            $display("FAIL fips_r0: key=%h, want %h", rk_key_out, FIPS_KEY);
        end
    endtask

    task automatic test_decrypt_order();
        @(negedge CLK);
        for (int i = 10; i >= 0; i--) rd(4'(i), (i == 10) ? 1 : 2, i != 0);
    endtask

    task automatic test_bad_index();
        @(negedge CLK);
        rd(4'd11, 1, 1'b0);
        @(negedge CLK);
        rd(4'd15, 1, 1'b0);
    endtask

    task automatic test_load_during_capt();
        @(negedge CLK);
        expand_and_check(rand128(), 5, "capt_load");
        @(negedge CLK);
        rd(4'd3, 1, 1'b0);
        @(negedge CLK);
        rd(4'd10, 1, 1'b0);
    endtask

    task automatic test_load_vs_read();
        exp_t        e;
        logic [127:0] k;
        int          first_ready;
        int          ack_n;
        bit          early_ack;
        k           = rand128();
        first_ready = 0;
        ack_n       = 0;
        early_ack   = 1'b0;
        @(negedge CLK);
        key_load_in = 1'b1;
        key_in      = k;
        rk_req_in   = 1'b1;
        rk_idx_in   = 4'd5;
        cur_s       = expand(k);
        e.key = cur_s[5];
        e.err = 1'b0;
        sb_q.push_back(e);
        for (int n = 1; n <= 30; n++) begin
            @(negedge CLK);
            if (n == 1) key_load_in = 1'b0;
            if (key_ready_out && first_ready == 0) first_ready = n;
            if (rk_ack_out) begin
                ack_n = n;
                if (n <= 13) early_ack = 1'b1;
                break;
            end
        end
        e = sb_q.pop_front();
        tests++;
        if (early_ack || first_ready != 13 || ack_n != 14) begin
            fails++;
            $display("FAIL contention_timing: ready at T+%0d ack at T+%0d early=%b, want ready T+13 ack T+14 early=0",
                     first_ready, ack_n, early_ack);
        end
        tests++;
        if (rk_key_out !== e.key || rk_err_out !== 1'b0) begin
            fails++;
            $display("FAIL contention_data: key=%h err=%b, want key=%h err=0", rk_key_out, rk_err_out, e.key);
        end
        $display("[TB] contention read idx=5 ready=T+%0d ack=T+%0d key=%h", first_ready, ack_n, rk_key_out);
        rk_req_in = 1'b0;
    endtask

    task automatic test_fault_timeout();
        int fault_n;
        fault_n  = 0;
        eng_mode = 1;
        @(negedge CLK);
        key_load_in = 1'b1;
        key_in      = rand128();
        for (int n = 1; n <= 36; n++) begin
            @(negedge CLK);
            if (n == 1) key_load_in = 1'b0;
            if (fault_out && fault_n == 0) begin
                fault_n = n;
                tests++;
                if (key_busy_out !== 1'b0 || ke_start_out !== 1'b0 || key_ready_out !== 1'b0) begin
                    fails++;
                    $display("FAIL timeout_idle: busy=%b start=%b ready=%b, want 0 0 0",
                             key_busy_out, ke_start_out, key_ready_out);
                end
            end
        end
        tests++;
        if (fault_n != TIMEOUT + 1) begin
            fails++;
            $display("FAIL timeout_cycle: fault at T+%0d, want T+%0d", fault_n, TIMEOUT + 1);
        end
        $display("[TB] timeout fault at T+%0d", fault_n);
    endtask

    task automatic test_fault_drop();
        int  fault_n;
        bit  saw_ready;
        fault_n   = 0;
        saw_ready = 1'b0;
        eng_mode  = 2;
        @(negedge CLK);
        key_load_in = 1'b1;
        key_in      = rand128();
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            if (n == 1) begin
                key_load_in = 1'b0;
                tests++;
                if (fault_out !== 1'b0) begin
                    fails++;
                    $display("FAIL drop_clear: fault=%b, want 0 after accepted load", fault_out);
                end
            end
            if (key_ready_out) saw_ready = 1'b1;
            if (fault_out && fault_n == 0) fault_n = n;
        end
        tests++;
        if (fault_n != 8 || saw_ready || key_busy_out !== 1'b0) begin
            fails++;
            $display("FAIL drop_fault: fault at T+%0d ready_seen=%b busy=%b, want T+8 0 0", fault_n, saw_ready, key_busy_out);
        end
        $display("[TB] dropped engine fault at T+%0d", fault_n);
        eng_mode = 0;
    endtask

    task automatic test_fault_clear();
        @(negedge CLK);
        expand_and_check(rand128(), 0, "recover");
        tests++;
        if (fault_out !== 1'b0) begin
            fails++;
            $display("FAIL recover_fault: fault=%b, want 0", fault_out);
        end
        @(negedge CLK);
        rd(4'd2, 1, 1'b0);
    endtask

    task automatic test_async_reset();
        logic [127:0] k;
        k = rand128();
        @(negedge CLK);
        key_load_in = 1'b1;
        key_in      = k;
        repeat (4) begin
            @(negedge CLK);
            key_load_in = 1'b0;
        end
        #2 RST = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_all_zero("after_async_reset");
        expand_and_check(k, 0, "post_reset");
        @(negedge CLK);
        rd(4'd7, 1, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_decrypt_order();
        test_bad_index();
        test_load_during_capt();
        test_load_vs_read();
        test_fault_timeout();
        test_fault_drop();
        test_fault_clear();
        test_async_reset();
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover: %0d entries, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
